// File: rtl/tetris_input_pkg.sv
// Shared types and constants for the push-button input path.
// Holds key FSM states, default timing and the game core cooldown.
package tetris_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCKED = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_FRAMES_DEF = 2;
  localparam int DAS_DELAY_DEF       = 20;
  localparam int DAS_REPEAT_DEF      = 15;

  // Game core accepts at most one request per key in this many frames.
  localparam int COOLDOWN_FRAMES = 15;

  localparam int DB_W  = 3;
  localparam int DAS_W = 6;

endpackage

// File: rtl/key_channel.sv
// One push button: 2-flop synchroniser, debounce and request FSM.
// Ports: clock_framerate, resetn (sync, active-low), raw_n (async,
// active-low), allow (enable and no conflict), held (debounced and
// staying pressed this frame), pulse (registered one-frame request).
module key_channel
  import tetris_input_pkg::*;
#(
  parameter bit AUTO_REPEAT     = 1'b1,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
  parameter int DAS_DELAY       = DAS_DELAY_DEF,
  parameter int DAS_REPEAT      = DAS_REPEAT_DEF
) (
  input  logic clock_framerate,
  input  logic resetn,
  input  logic raw_n,
  input  logic allow,
  output logic held,
  output logic pulse
);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [DAS_W-1:0] DELAY_LAST =
    DAS_W'(DAS_DELAY - 1);
  localparam logic [DAS_W-1:0] REPEAT_LAST =
    DAS_W'(DAS_REPEAT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  key_state_t       state_q, state_d;
  logic [DAS_W-1:0] das_cnt_q, das_cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync1_d  = raw_n;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (~sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    // A release completing this frame already blocks the pulse.
    held = deb_q & deb_d;
  end

  always_comb begin
    state_d   = state_q;
    das_cnt_d = das_cnt_q;
    pulse_d   = 1'b0;
    if (!held) begin
      state_d   = ST_IDLE;
      das_cnt_d = '0;
    end else if (!allow) begin
      state_d   = ST_LOCKED;
      das_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pulse_d   = 1'b1;
          das_cnt_d = '0;
          state_d   = AUTO_REPEAT ? ST_DELAY : ST_LOCKED;
        end
        ST_DELAY: begin
          if (das_cnt_q == DELAY_LAST) begin
            pulse_d   = 1'b1;
            das_cnt_d = '0;
            state_d   = ST_REPEAT;
          end else begin
            das_cnt_d = das_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (das_cnt_q == REPEAT_LAST) begin
            pulse_d   = 1'b1;
            das_cnt_d = '0;
          end else begin
            das_cnt_d = das_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      das_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      das_cnt_q <= das_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// Turns three raw buttons into clean one-frame game requests.
// Ports: clock_framerate, resetn (sync, active-low), enable,
// raw_left_n/raw_right_n/raw_rotate_n (async, active-low),
// key_left/key_right/key_rotate (registered one-frame pulses).
module key_conditioner
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
  parameter int DAS_DELAY       = DAS_DELAY_DEF,
  parameter int DAS_REPEAT      = DAS_REPEAT_DEF
) (
  input  logic clock_framerate,
  input  logic resetn,
  input  logic enable,
  input  logic raw_left_n,
  input  logic raw_right_n,
  input  logic raw_rotate_n,
  output logic key_left,
  output logic key_right,
  output logic key_rotate
);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7) begin : g_bad_db
    $error("DEBOUNCE_FRAMES out of range 1..7");
  end
  if (DAS_DELAY < COOLDOWN_FRAMES || DAS_DELAY > 63) begin : g_bad_dd
    $error("DAS_DELAY out of range");
  end
  if (DAS_REPEAT < COOLDOWN_FRAMES || DAS_REPEAT > 63) begin : g_bad_dr
    $error("DAS_REPEAT out of range");
  end

  logic held_l, held_r, held_t;
  logic allow_lr;

  // Both directions held at once locks both until re-pressed.
  assign allow_lr = enable & ~(held_l & held_r);

  key_channel #(
    .AUTO_REPEAT     (1'b1),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .DAS_DELAY       (DAS_DELAY),
    .DAS_REPEAT      (DAS_REPEAT)
  ) u_left (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .raw_n           (raw_left_n),
    .allow           (allow_lr),
    .held            (held_l),
    .pulse           (key_left)
  );

  key_channel #(
    .AUTO_REPEAT     (1'b1),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .DAS_DELAY       (DAS_DELAY),
    .DAS_REPEAT      (DAS_REPEAT)
  ) u_right (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .raw_n           (raw_right_n),
    .allow           (allow_lr),
    .held            (held_r),
    .pulse           (key_right)
  );

  key_channel #(
    .AUTO_REPEAT     (1'b0),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .DAS_DELAY       (DAS_DELAY),
    .DAS_REPEAT      (DAS_REPEAT)
  ) u_rotate (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .raw_n           (raw_rotate_n),
    .allow           (enable),
    .held            (held_t),
    .pulse           (key_rotate)
  );

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: pulse-time tables,
// corner-case sequences and a random run against a frame model.
module tb_key_conditioner;

  localparam int DB = 2;
  localparam int DD = 20;
  localparam int DR = 15;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  logic rl = 1'b1, rr = 1'b1, rt = 1'b1;
  logic kl, kr, kt;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit chk_on = 1'b0;
  int ql[$], qr[$], qt[$];

  key_conditioner #(
    .DEBOUNCE_FRAMES (DB),
    .DAS_DELAY       (DD),
    .DAS_REPEAT      (DR)
  ) dut (
    .clock_framerate (clk),
    .resetn          (resetn),
    .enable          (enable),
    .raw_left_n      (rl),
    .raw_right_n     (rr),
    .raw_rotate_n    (rt),
    .key_left        (kl),
    .key_right       (kr),
    .key_rotate      (kt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Frame model: delayed samples, run-length debounce, and
  // press age arithmetic for the repeat schedule.
  bit m_d1[3], m_d2[3], m_deb[3], m_held[3];
  bit m_act[3], m_lock[3], m_exp[3];
  int m_run[3], m_age[3];

  always @(posedge clk) begin
    bit raw[3];
    bit s, old, blocked;
    raw[0] = rl; raw[1] = rr; raw[2] = rt;
    if (!resetn) begin
      for (int k = 0; k < 3; k++) begin
        m_d1[k] = 1; m_d2[k] = 1; m_deb[k] = 0;
        m_run[k] = 0; m_act[k] = 0; m_lock[k] = 0;
        m_age[k] = 0; m_exp[k] = 0; m_held[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        s = !m_d2[k];
        m_d2[k] = m_d1[k];
        m_d1[k] = raw[k];
        old = m_deb[k];
        if (s != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_deb[k] = !m_deb[k];
            m_run[k] = 0;
          end
        end else m_run[k] = 0;
        m_held[k] = old && m_deb[k];
      end
      for (int k = 0; k < 3; k++) begin
        blocked = !enable || (k < 2 && m_held[0] && m_held[1]);
        m_exp[k] = 0;
        if (!m_held[k]) begin
          m_act[k] = 0; m_lock[k] = 0;
        end else if (blocked) begin
          m_act[k] = 0; m_lock[k] = 1;
        end else if (m_lock[k]) begin
          m_exp[k] = 0;
        end else if (!m_act[k]) begin
          m_exp[k] = 1;
          if (k < 2) begin m_act[k] = 1; m_age[k] = 0; end
          else m_lock[k] = 1;
        end else begin
          m_age[k]++;
          m_exp[k] = (m_age[k] == DD) ||
                     (m_age[k] > DD && (m_age[k] - DD) % DR == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (kl === 1'b1) ql.push_back(edge_n);
    if (kr === 1'b1) qr.push_back(edge_n);
    if (kt === 1'b1) qt.push_back(edge_n);
    if (chk_on) begin
      checks++;
      if ({kl, kr, kt} !== {m_exp[0], m_exp[1], m_exp[2]}) begin
        errors++;
        $display("FAIL model edge=%0d got=%b%b%b want=%b%b%b",
                 edge_n, kl, kr, kt, m_exp[0], m_exp[1], m_exp[2]);
      end
    end
  end

  task automatic frames(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: rl = v;
      1: rr = v;
      default: rt = v;
    endcase
  endtask

  task automatic run_hold(input int k, input int hold,
                          input int idle, output int e0);
    set_key(k, 1'b0);
    e0 = edge_n + 1;
    frames(hold);
    set_key(k, 1'b1);
    frames(idle);
  endtask

  task automatic check_bit(input string nm, input logic got,
                           input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic check_pulses(input string nm, input int k,
                              input int e0, input int ex[6]);
    int got[$];
    int n, g;
    n = 0;
    if (k == 0) begin
      foreach (ql[j]) if (ql[j] >= e0) got.push_back(ql[j] - e0);
    end else if (k == 1) begin
      foreach (qr[j]) if (qr[j] >= e0) got.push_back(qr[j] - e0);
    end else begin
      foreach (qt[j]) if (qt[j] >= e0) got.push_back(qt[j] - e0);
    end
    for (int i = 0; i < 6; i++) if (ex[i] >= 0) n++;
    checks++;
    if (got.size() != n) begin
      errors++;
      $display("FAIL %s key%0d count got=%0d want=%0d",
               nm, k, got.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      g = (i < got.size()) ? got[i] : -1;
      checks++;
      if (g != ex[i]) begin
        errors++;
        $display("FAIL %s key%0d pulse%0d got=%0d want=%0d",
                 nm, k, i, g, ex[i]);
      end
    end
  endtask

  task automatic check_all(input string nm, input int k,
                           input int e0, input int ex[6]);
    int none[6];
    none = '{-1, -1, -1, -1, -1, -1};
    for (int j = 0; j < 3; j++)
      check_pulses(nm, j, e0, (j == k) ? ex : none);
  endtask

  typedef struct packed {
    int key;
    int hold;
    int p0, p1, p2, p3, p4, p5;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int e0;
    int ex[6];
    vecs[0] = '{0, 60, 4, 24, 39, 54, -1, -1};
    vecs[1] = '{1, 30, 4, 24, -1, -1, -1, -1};
    vecs[2] = '{2, 100, 4, -1, -1, -1, -1, -1};
    vecs[3] = '{2, 10, 4, -1, -1, -1, -1, -1};
    vecs[4] = '{0, 1, -1, -1, -1, -1, -1, -1};
    vecs[5] = '{0, 2, 4, -1, -1, -1, -1, -1};
    vecs[6] = '{1, 21, 4, -1, -1, -1, -1, -1};
    vecs[7] = '{1, 22, 4, 24, -1, -1, -1, -1};
    vecs[8] = '{0, 40, 4, 24, 39, -1, -1, -1};
    vecs[9] = '{1, 3, 4, -1, -1, -1, -1, -1};

    resetn = 1'b0;
    frames(3);
    check_bit("reset_left", kl, 1'b0);
    check_bit("reset_right", kr, 1'b0);
    check_bit("reset_rotate", kt, 1'b0);
    resetn = 1'b1;
    chk_on = 1'b1;
    frames(5);

    for (int i = 0; i < 10; i++) begin
      run_hold(vecs[i].key, vecs[i].hold, 12, e0);
      ex = '{vecs[i].p0, vecs[i].p1, vecs[i].p2,
             vecs[i].p3, vecs[i].p4, vecs[i].p5};
      check_all($sformatf("vec%0d", i), vecs[i].key, e0, ex);
    end

    // Bouncing input, then a clean hold starting at frame 20.
    e0 = edge_n + 1;
    for (int i = 0; i < 20; i++) begin
      rl = (i % 2 == 1);
      frames(1);
    end
    rl = 1'b0;
    frames(10);
    rl = 1'b1;
    frames(12);
    check_all("bounce", 0, e0, '{24, -1, -1, -1, -1, -1});

    // Left held, right joins: both lock, left stays locked.
    rl = 1'b0;
    e0 = edge_n + 1;
    frames(10);
    rr = 1'b0;
    frames(50);
    rr = 1'b1;
    frames(40);
    rl = 1'b1;
    frames(12);
    check_all("conflict", 0, e0, '{4, -1, -1, -1, -1, -1});
    run_hold(0, 10, 12, e0);
    check_all("conflict_repress", 0, e0, '{4, -1, -1, -1, -1, -1});

    // Key held across enable rising stays silent.
    enable = 1'b0;
    rl = 1'b0;
    e0 = edge_n + 1;
    frames(30);
    enable = 1'b1;
    frames(30);
    rl = 1'b1;
    frames(12);
    check_all("enable_hold", 0, e0, '{-1, -1, -1, -1, -1, -1});
    run_hold(0, 10, 12, e0);
    check_all("enable_repress", 0, e0, '{4, -1, -1, -1, -1, -1});

    // Reset while repeating restarts the whole press.
    rl = 1'b0;
    e0 = edge_n + 1;
    frames(45);
    resetn = 1'b0;
    frames(1);
    check_bit("midreset_left", kl, 1'b0);
    check_bit("midreset_right", kr, 1'b0);
    check_bit("midreset_rotate", kt, 1'b0);
    resetn = 1'b1;
    frames(44);
    rl = 1'b1;
    frames(12);
    check_all("midreset", 0, e0, '{4, 24, 39, 50, 70, 85});

    // Random buttons, enable and reset against the frame model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 23) == 0) rl = ~rl;
      if ($urandom_range(0, 23) == 0) rr = ~rr;
      if ($urandom_range(0, 15) == 0) rt = ~rt;
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 24) == 0) enable = 1'b1;
      resetn = ($urandom_range(0, 1499) != 0);
      frames(1);
    end
    rl = 1'b1; rr = 1'b1; rt = 1'b1;
    enable = 1'b1;
    resetn = 1'b1;
    frames(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage directly upstream of the game core. It takes the three raw, asynchronous, active-low push-button inputs and converts them into clean single-frame move/rotate requests (`key_left`, `key_right`, `key_rotate`) on the frame clock. Each key is synchronised and debounced; left/right also get delayed auto-shift (DAS) repeat. Rotate is edge-only. Repeat timing respects the game core's 15-frame per-key acceptance window.

## Interface
Parameters:
- DEBOUNCE_FRAMES, 2: consecutive identical synchronised samples required to change a key's debounced level (1..7).
- DAS_DELAY, 20: frames from the initial left/right pulse to the first auto-repeat pulse (15..63).
- DAS_REPEAT, 15: frames between subsequent auto-repeat pulses (15..63).

Ports:
- clock_framerate  in  1  frame clock (~60 Hz); all state on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  high = game accepting input; low = outputs suppressed.
- raw_left_n  in  1  raw left button, active-low, asynchronous.
- raw_right_n  in  1  raw right button, active-low, asynchronous.
- raw_rotate_n  in  1  raw rotate button, active-low, asynchronous.
- key_left  out  1  one-frame move-left request.
- key_right  out  1  one-frame move-right request.
- key_rotate  out  1  one-frame rotate request.

## Operation
- Per key: 2-flop synchroniser (reset to released = 1), inverted to active-high. Debounce counter: debounced level flips only after DEBOUNCE_FRAMES consecutive synchronised samples differ from the current debounced level. Any mismatch-free sample resets the counter.
- Per-key FSM states: IDLE, DELAY, REPEAT, LOCKED.
  - IDLE: on debounced rise with enable=1 and not in conflict, emit pulse -> DELAY (left/right), or stay in IDLE-held (rotate, no repeat; treated as LOCKED until release).
  - DELAY: count DAS_DELAY frames; at terminal count, emit pulse -> REPEAT.
  - REPEAT: emit a pulse every DAS_REPEAT frames.
  - Any state: debounced release -> IDLE, with no pulse on release.
  - LOCKED: no pulses; debounced release -> IDLE.
- enable=0: all outputs forced 0. Any key with debounced level pressed -> LOCKED, others -> IDLE. A key held through enable rising produces no pulse until it is released and re-pressed.
- Left/right conflict: while both are debounced-pressed, neither emits and both go to LOCKED. Releasing one leaves the other LOCKED. No pulse until it is re-pressed.
- Rotate is fully independent of left/right; simultaneous pulses on different outputs are allowed.
- DAS counters are 6 bits and saturate or reload only at their terminal count; no wrap-around is ever visible.

## Timing
- Reset: key_left/key_right/key_rotate = 0, all FSMs IDLE, counters 0, debounced levels released. Reset applied mid-hold behaves as a fresh release: the key must be seen pressed for the full debounce time again and then pulses as a new press.
- Press latency: raw low first sampled at edge E0 and held -> pulse high for exactly the cycle after edge E0+2+DEBOUNCE_FRAMES (defaults: E0+4).
- Left/right held: next pulses after edges E0+4+DAS_DELAY, then every +DAS_REPEAT (defaults: E0+4, E0+24, E0+39, E0+54, ...).
- Release latency: raw high at edge R0 -> no pulses issued after edge R0+1+DEBOUNCE_FRAMES.
- Outputs are registered; each pulse is exactly one clock_framerate cycle wide.
- Bounce shorter than DEBOUNCE_FRAMES samples produces no pulse and no release.

## Structure
- Shared package tetris_input_pkg holds:
  - the FSM state typedef (IDLE, DELAY, REPEAT, LOCKED);
  - default constants for DEBOUNCE_FRAMES, DAS_DELAY and DAS_REPEAT;
  - the consumer cooldown constant (15), used for parameter range checks.
- Sub-module key_channel (parameter AUTO_REPEAT) contains the synchroniser, debounce and FSM. It is instantiated three times: left and right with AUTO_REPEAT=1, rotate with AUTO_REPEAT=0. The top level adds the left/right conflict and enable gating.

## Test plan
- Reset, then hold raw_left_n=0 from E0 with enable=1 -> key_left high only in the cycles after E0+4, E0+24, E0+39, E0+54; key_right and key_rotate stay 0.
- Rotate held 100 frames -> exactly one key_rotate pulse, after E0+4. Release, then re-press -> second pulse 4 frames after the re-press.
- Left raw toggles 0/1 every frame for 20 frames -> no pulse. Then held low -> pulse 4 frames after the hold starts.
- Left held, right pressed 10 frames later -> after the right debounce completes, no further pulses on either output. Release right while left stays held -> still no pulses until left is re-pressed.
- Left held with enable=0, enable rises at frame 30 -> no pulse. Release and re-press -> normal pulse at +4.
- Left held and in REPEAT, resetn=0 for 1 frame -> outputs 0 during reset. After release of reset with the key still held, first pulse at 4 frames, then DAS_DELAY restarts.
